button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Conditions raw, asynchronous, bouncing push-button levels into clean, clock-synchronous levels.
//  Output is a calc_pkg::buttons_t, one bit per key.
//  Sits directly upstream of the button sanitizer: buttons_o feeds its buttons_i unchanged.
//  Each bit has its own synchronizer and its own stability counter.
//  A shared prescaler tick sets the sampling rate.
// PARAMETERS
//  SYNC_STAGES   2      flops in each per-bit synchronizer chain; must be >= 2
//  TICK_DIV      50000  clk cycles per sample tick; 1 = sample every cycle; must be >= 1
//  STABLE_TICKS  8      consecutive disagreeing ticks needed to flip a stable bit; must be >= 1
//  ACTIVE_LOW    0      1 = raw pins read 0 when pressed; inverted before the synchronizer
// PORTS
//  clk_i           in   1                           single system clock
//  rst_i           in   1                           synchronous, active-high reset
//  buttons_raw_i   in   $bits(calc_pkg::buttons_t)  raw pin levels, asynchronous to clk_i
//  buttons_o       out  calc_pkg::buttons_t         debounced levels, 1 = pressed
//  any_pressed_o   out  1                           |buttons_o
// BEHAVIOUR
//  Clocking and reset
//   - One clock. Reset is synchronous and active-high; the clock/reset ports are named clk_i and rst_i.
//   - On rst_i the following all clear to 0: sync flops, prescaler, tick, per-bit counters, stable bits.
//   - Reset values: buttons_o = '0, any_pressed_o = 0.
//  Input conditioning
//   - ACTIVE_LOW is applied first (raw is XOR'd with {N{ACTIVE_LOW}}).
//   - The result enters a SYNC_STAGES-deep flop chain; sync[b] is the last stage.
//  Prescaler
//   - pcnt counts 0..TICK_DIV-1 and wraps.
//   - tick is 1 for exactly the one cycle in which pcnt == TICK_DIV-1.
//   - When TICK_DIV == 1, tick is 1 every cycle after reset.
//  Per-bit FSM (states are implicit in stable[b] and cnt[b])
//   - AGREE, sync == stable: cnt <= 0 every cycle, regardless of tick.
//   - DISAGREE and tick and cnt == STABLE_TICKS-1: stable <= sync and cnt <= 0.
//   - DISAGREE and tick, otherwise: cnt <= cnt+1.
//   - DISAGREE and no tick: cnt holds.
//   - A single agreeing cycle (bounce) discards the accumulated count. The release path is symmetric to the press path.
//  Arithmetic
//   - cnt width = max(1, $clog2(STABLE_TICKS)).
//   - pcnt width = max(1, $clog2(TICK_DIV)).
//   - Neither counter can exceed its terminal value.
//  Latency (TICK_DIV == 1)
//   - A clean raw edge reaches buttons_o exactly SYNC_STAGES + STABLE_TICKS cycles later.
//  Latency (general case)
//   - SYNC_STAGES + (STABLE_TICKS-1)*TICK_DIV + 1 cycles minimum.
//   - SYNC_STAGES + STABLE_TICKS*TICK_DIV cycles maximum.
//  Outputs
//   - buttons_o is driven directly from the stable registers (no combinational path from raw).
//   - any_pressed_o is combinational OR of the stable registers.
//  Simultaneous events
//   - Bits are fully independent: several bits may be stable-high at once.
//   - Multiple bits may flip on the same clock edge.
//   - Key priority is the downstream stage's job.
//  Reset mid-operation
//   - A bit that is mid-count or stable-high returns to 0 at reset.
//   - A key still held after reset deasserts requires the full latency to reappear.
//  Elaboration checks
//   - $error if SYNC_STAGES < 2, TICK_DIV < 1 or STABLE_TICKS < 1.
// TESTING (TICK_DIV=1, STABLE_TICKS=4, SYNC_STAGES=2, ACTIVE_LOW=0 unless stated)
//  1 Clean press/release of num_5: raw 0->1 at cycle 0.
//    -> buttons_o.num_5 = 1 from cycle 6.
//    -> Raw 1->0 at cycle 20: num_5 = 0 from cycle 26. any_pressed_o tracks num_5.
//  2 Bounce: raw op_add toggles 1,0,1,0,1 on successive cycles, then stays 1.
//    -> No output pulse during the bounce.
//    -> op_add = 1 exactly 6 cycles after the final 0->1.
//  3 Glitch: 3-cycle high pulse on clear.
//    -> buttons_o stays '0 for 50 cycles.
//  4 Simultaneous: num_1 and op_eq rise on the same cycle.
//    -> Both bits rise on the same cycle, 6 cycles later.
//  5 Prescaler: TICK_DIV=10, raw dot held high.
//    -> Rise lands in the window [2+31, 2+40] cycles after the raw edge.
//    -> A 25-cycle pulse never propagates.
//  6 Reset: assert rst_i 1 cycle while num_9 is stable-high and held.
//    -> buttons_o = '0 the next cycle.
//    -> num_9 = 1 again 6 cycles after rst_i deasserts.
//  7 ACTIVE_LOW=1, raw all-ones idle.
//    -> buttons_o = '0.
//    -> Driving raw.mem_add low for 10 cycles -> mem_add = 1 after 6 cycles.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared calculator types: one bit per front-panel key, 1 = pressed.
package calc_pkg;

    typedef struct packed {
        logic num_0;
        logic num_1;
        logic num_2;
        logic num_3;
        logic num_4;
        logic num_5;
        logic num_6;
        logic num_7;
        logic num_8;
        logic num_9;
        logic dot;
        logic op_add;
        logic op_sub;
        logic op_mul;
        logic op_div;
        logic op_eq;
        logic clear;
        logic mem_add;
        logic mem_sub;
        logic mem_recall;
    } buttons_t;

endpackage

// File: rtl/button_debounce.sv
// Purpose: synchronize and debounce raw push-button pins into clean per-key levels.
// Latency: SYNC_STAGES + STABLE_TICKS cycles at TICK_DIV=1; up to SYNC_STAGES + STABLE_TICKS*TICK_DIV otherwise.
// Backpressure: none; level outputs are always valid and the raw inputs are sampled every cycle.
module button_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8,
    parameter bit ACTIVE_LOW   = 1'b0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [$bits(calc_pkg::buttons_t)-1:0] buttons_raw_i,
    output calc_pkg::buttons_t                   buttons_o,
    output logic                                 any_pressed_o
);

    localparam int N  = $bits(calc_pkg::buttons_t);
    localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [PW-1:0] PCNT_LAST = PW'(TICK_DIV - 1);

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("button_debounce: SYNC_STAGES must be >= 2");
        end
        if (TICK_DIV < 1) begin : g_bad_div
            $error("button_debounce: TICK_DIV must be >= 1");
        end
        if (STABLE_TICKS < 1) begin : g_bad_ticks
            $error("button_debounce: STABLE_TICKS must be >= 1");
        end
    endgenerate

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic [N-1:0]  sync_d [SYNC_STAGES];
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          tick;
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic [N-1:0]  stable_q;
    logic [N-1:0]  stable_d;
    logic [N-1:0]  sync_last;

    // Polarity is normalised before the first flop so every later stage sees 1 = pressed.
    always_comb begin
        sync_d[0] = buttons_raw_i ^ {N{ACTIVE_LOW}};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
        tick   = (pcnt_q == PCNT_LAST);
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    end

    // Any agreeing cycle clears the count, so a bounce restarts the whole qualification window.
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < N; b++) begin
            cnt_d[b] = cnt_q[b];
            if (sync_last[b] == stable_q[b]) begin
                cnt_d[b] = '0;
            end else if (tick) begin
                if (cnt_q[b] == CNT_LAST) begin
                    stable_d[b] = sync_last[b];
                    cnt_d[b]    = '0;
                end else begin
                    cnt_d[b] = cnt_q[b] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int b = 0; b < N; b++) begin
                cnt_q[b] <= '0;
            end
            pcnt_q   <= '0;
            stable_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int b = 0; b < N; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            pcnt_q   <= pcnt_d;
            stable_q <= stable_d;
        end
    end

    assign buttons_o     = calc_pkg::buttons_t'(stable_q);
    assign any_pressed_o = |stable_q;

endmodule
